// File: rtl/d7_scan_arbiter.sv
// Eight-digit multiplexed 7-segment scanner shared by an application and an alert requester.
// Outputs are registered one cycle behind the scan counter; requesters see no backpressure, only grant.
module d7_scan_arbiter #(
    parameter int SCAN_DIV       = 100000,
    parameter int SCAN_DIV_TURBO = 16,
    parameter int BLANK          = 200,
    parameter int BLANK_TURBO    = 2,
    parameter int MAX_ALERT      = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        turbosim,
    input  logic        req_0,
    input  logic [63:0] seg_0,
    input  logic        req_1,
    input  logic [63:0] seg_1,
    input  logic [2:0]  brightness,
    output logic [1:0]  grant,
    output logic [7:0]  d7_cathodes_n,
    output logic [7:0]  d7_anodes,
    output logic        frame_done
);

    localparam int DIV_MAX = (SCAN_DIV > SCAN_DIV_TURBO) ? SCAN_DIV : SCAN_DIV_TURBO;
    localparam int CW      = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;
    localparam int WW      = CW + 4;
    localparam int SW      = (MAX_ALERT > 0) ? $clog2(MAX_ALERT + 1) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    dig_q, dig_d;
    logic [1:0]    grant_q, grant_d;
    logic [SW-1:0] sc_q, sc_d;
    logic [7:0]    byte_q, byte_d;
    logic [7:0]    anodes_q, anodes_d;
    logic [7:0]    cath_q, cath_d;
    logic          fd_q, fd_d;

    logic [WW-1:0] div_w, blk_w, cnt_w, bmul, on_len, win_end;
    logic          last_cnt, boundary, slot_start, anode_on, starved;
    logic [1:0]    arb_grant;
    logic [63:0]   src_seg;
    logic [7:0]    field, disp_byte;

    // Scan geometry: the on-window is an eighth of the unblanked slot per brightness step.
    always_comb begin
        div_w    = turbosim ? WW'(SCAN_DIV_TURBO) : WW'(SCAN_DIV);
        blk_w    = turbosim ? WW'(BLANK_TURBO) : WW'(BLANK);
        cnt_w    = WW'(cnt_q);
        bmul     = WW'({1'b0, brightness}) + WW'(1);
        on_len   = ((div_w - blk_w) >> 3) * bmul;
        win_end  = blk_w + on_len;
        last_cnt = (cnt_w == div_w - WW'(1));
        boundary = last_cnt && (dig_q == 3'd7);
        slot_start = (cnt_q == '0);
        cnt_d    = last_cnt ? '0 : cnt_q + CW'(1);
        dig_d    = last_cnt ? dig_q + 3'd1 : dig_q;
    end

    // Alert wins unless it has already held MAX_ALERT frames while the application waited.
    always_comb begin
        starved   = (sc_q == SW'(MAX_ALERT)) && req_0;
        arb_grant = 2'b00;
        if (req_1 && !starved) begin
            arb_grant = 2'b10;
        end else if (req_0) begin
            arb_grant = 2'b01;
        end
        grant_d = boundary ? arb_grant : grant_q;
        sc_d    = sc_q;
        if (boundary) begin
            if (arb_grant == 2'b01 || !req_0) begin
                sc_d = '0;
            end else if (arb_grant == 2'b10 && sc_q != SW'(MAX_ALERT)) begin
                sc_d = sc_q + SW'(1);
            end
        end
    end

    // The byte is captured at slot start; bypass the capture so a zero-length blank still shows it.
    always_comb begin
        src_seg   = grant_q[1] ? seg_1 : seg_0;
        field     = src_seg[{dig_q, 3'b000} +: 8];
        byte_d    = byte_q;
        if (slot_start) begin
            byte_d = (grant_q == 2'b00) ? 8'h00 : field;
        end
        disp_byte = slot_start ? field : byte_q;
        anode_on  = (grant_q != 2'b00) && (cnt_w >= blk_w) && (cnt_w < win_end);
        anodes_d  = anode_on ? (8'b1 << dig_q) : 8'h00;
        cath_d    = anode_on ? ~disp_byte : 8'hFF;
        fd_d      = boundary;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            dig_q    <= 3'd0;
            grant_q  <= 2'b00;
            sc_q     <= '0;
            byte_q   <= 8'h00;
            anodes_q <= 8'h00;
            cath_q   <= 8'hFF;
            fd_q     <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            dig_q    <= dig_d;
            grant_q  <= grant_d;
            sc_q     <= sc_d;
            byte_q   <= byte_d;
            anodes_q <= anodes_d;
            cath_q   <= cath_d;
            fd_q     <= fd_d;
        end
    end

    assign grant         = grant_q;
    assign d7_anodes     = anodes_q;
    assign d7_cathodes_n = cath_q;
    assign frame_done    = fd_q;

endmodule

// File: tb/tb_d7_scan_arbiter.sv
// Bench for d7_scan_arbiter in turbo mode: positional reference model plus directed literal checks.
`timescale 1ns/1ps
module tb_d7_scan_arbiter;

    logic        clk = 1'b0;
    logic        reset, turbosim, req_0, req_1;
    logic [63:0] seg_0, seg_1;
    logic [2:0]  brightness;
    logic [1:0]  grant;
    logic [7:0]  d7_cathodes_n, d7_anodes;
    logic        frame_done;

    int vec = 0;
    int err = 0;

    d7_scan_arbiter dut (
        .clk(clk), .reset(reset), .turbosim(turbosim),
        .req_0(req_0), .seg_0(seg_0), .req_1(req_1), .seg_1(seg_1),
        .brightness(brightness), .grant(grant),
        .d7_cathodes_n(d7_cathodes_n), .d7_anodes(d7_anodes), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Model: p counts cycles since reset release; slot = p%16, digit = (p/16)%8, frame = p/128.
    int         p = 0;
    int         run, slot, d, w;
    logic [1:0] mg;
    logic [7:0] mbyte, e_an, e_cat;
    logic [1:0] e_gr;
    logic       e_fd;
    bit         mvalid = 0;

    initial begin
        forever begin
            @(posedge clk);
            if (reset) begin
                p = 0; mg = 2'b00; run = 0; mbyte = 8'h00;
                e_an = 8'h00; e_cat = 8'hFF; e_gr = 2'b00; e_fd = 1'b0;
                mvalid = 1;
            end else begin
                slot = p % 16;
                d    = (p / 16) % 8;
                if (slot == 0)
                    mbyte = (mg == 2'b10) ? seg_1[d*8 +: 8] : (mg == 2'b01) ? seg_0[d*8 +: 8] : 8'h00;
                w = int'(brightness) + 1;
                if (mg != 2'b00 && slot >= 2 && slot < 2 + w) begin
                    e_an  = 8'h01 << d;
                    e_cat = ~mbyte;
                end else begin
                    e_an  = 8'h00;
                    e_cat = 8'hFF;
                end
                e_fd = (p % 128 == 127);
                if (e_fd) begin
                    if (req_1 && !(req_0 && run >= 15)) mg = 2'b10;
                    else if (req_0)                     mg = 2'b01;
                    else                                mg = 2'b00;
                    run = (mg == 2'b10 && req_0) ? run + 1 : 0;
                end
                e_gr = mg;
                p++;
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        vec++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s at p=%0d: got %h want %h", name, p, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (mvalid) begin
                chk("model_grant", {6'b0, grant}, {6'b0, e_gr});
                chk("model_anodes", d7_anodes, e_an);
                chk("model_cathodes", d7_cathodes_n, e_cat);
                chk("model_frame_done", {7'b0, frame_done}, {7'b0, e_fd});
            end
        end
    end

    task automatic wait_p(input int q);
        int g = 0;
        while (p < q && g < 10000) begin
            @(negedge clk);
            g++;
        end
        vec++;
        if (p != q) begin
            err++;
            $display("FAIL wait_p: reached %0d want %0d", p, q);
        end
    endtask

    initial begin
        int hi;
        reset = 1'b1; turbosim = 1'b1; req_0 = 1'b0; req_1 = 1'b0; brightness = 3'd7;
        for (int k = 0; k < 8; k++) begin
            seg_0[k*8 +: 8] = 8'(k + 1);
            seg_1[k*8 +: 8] = 8'(8'hA0 + k);
        end
        repeat (2) @(negedge clk);
        chk("rst_grant", {6'b0, grant}, 8'h00);
        chk("rst_anodes", d7_anodes, 8'h00);
        chk("rst_cathodes", d7_cathodes_n, 8'hFF);
        chk("rst_frame_done", {7'b0, frame_done}, 8'h00);
        req_0 = 1'b1;
        reset = 1'b0;

        wait_p(127); chk("idle_grant", {6'b0, grant}, 8'h00);
        wait_p(128); chk("first_grant", {6'b0, grant}, 8'h01);
        chk("first_fd", {7'b0, frame_done}, 8'h01);
        wait_p(178); chk("blank_d3", d7_anodes, 8'h00);
        wait_p(179); chk("on_d3", d7_anodes, 8'h08);
        chk("cath_d3", d7_cathodes_n, 8'hFB);
        wait_p(186); chk("on_d3_end", d7_anodes, 8'h08);
        wait_p(187); chk("off_d3", d7_anodes, 8'h00);
        chk("off_cath_d3", d7_cathodes_n, 8'hFF);

        wait_p(256);
        brightness = 3'd0;
        hi = 0;
        for (int i = 0; i < 128; i++) begin
            @(negedge clk);
            if (d7_anodes != 8'h00) hi++;
        end
        chk("dim_on_cycles", 8'(hi), 8'd8);
        brightness = 3'd7;

        wait_p(400); req_1 = 1'b1;
        wait_p(511); chk("hold_grant", {6'b0, grant}, 8'h01);
        wait_p(512); chk("alert_grant", {6'b0, grant}, 8'h02);
        chk("alert_fd", {7'b0, frame_done}, 8'h01);

        wait_p(2368); chk("alert_f18", {6'b0, grant}, 8'h02);
        wait_p(2433); chk("starve_f19", {6'b0, grant}, 8'h01);
        wait_p(2469);
        seg_0[23:16] = 8'h5A;
        seg_0[31:24] = 8'h77;
        wait_p(2471); chk("midslot_an", d7_anodes, 8'h04);
        chk("midslot_old", d7_cathodes_n, 8'hFC);
        wait_p(2483); chk("nextslot_an", d7_anodes, 8'h08);
        chk("nextslot_new", d7_cathodes_n, 8'h88);
        wait_p(2561); chk("alert_f20", {6'b0, grant}, 8'h02);

        wait_p(2755);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_an", d7_anodes, 8'h00);
        chk("rst_mid_cath", d7_cathodes_n, 8'hFF);
        chk("rst_mid_grant", {6'b0, grant}, 8'h00);
        @(negedge clk);
        reset = 1'b0;
        wait_p(127); chk("regrant_pre", {6'b0, grant}, 8'h00);
        wait_p(128); chk("regrant", {6'b0, grant}, 8'h02);
        chk("regrant_fd", {7'b0, frame_done}, 8'h01);

        wait_p(168); req_1 = 1'b0;
        wait_p(179); chk("withdraw_an", d7_anodes, 8'h08);
        chk("withdraw_cath", d7_cathodes_n, 8'h5C);
        wait_p(255); chk("withdraw_keep", {6'b0, grant}, 8'h02);
        wait_p(256); chk("withdraw_regrant", {6'b0, grant}, 8'h01);
        wait_p(300);

        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
